dmem_responder: RTL

- Memory-side responder for the core's data-memory interface: word-addressed RAM with a request/ready handshake and configurable wait states.
- The core drives address, write data and write strobe; this block returns read data, ready and error.
- Sits between the pipelined core's memory stage and the on-chip data RAM, replacing the zero-latency combinational memory model.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_array.sv | 24 ++
 rtl/dmem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Types and constants shared by the data-memory responder and the planned instruction-memory one.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } mem_state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'(WORD_BYTES - 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;

endpackage

// File: rtl/mem_array.sv
// Word RAM with a synchronous write port and an asynchronous read port; deliberately reset-free.
module mem_array #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word request, waits WAIT_STATES cycles, then pulses MemReady.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output logic        Busy
);

    mem_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic                  wr_q;
    logic [31:0]           wdata_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [1:0]            err_q;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] req_idx, sel_idx;
    logic [1:0]            req_err, sel_err;
    logic [31:0]           ram_rdata;
    logic                  ram_we;

    function automatic logic [1:0] addr_err(logic [31:0] a);
        if ((a[1:0] & ALIGN_MASK) != 2'b00) return ERR_MISALIGN;
        if (a[31:ADDR_WIDTH+2] != '0) return ERR_RANGE;
        return ERR_NONE;
    endfunction

    always_comb begin
        req_idx = Addr[ADDR_WIDTH+1:2];
        req_err = addr_err(Addr);
        accept  = (state_q == StIdle) && MemReq;
        // With zero wait states RESP is entered on the accepting edge, before the latch is valid.
        sel_idx = accept ? req_idx : idx_q;
        sel_err = accept ? req_err : err_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (MemReq) begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_d == StResp) && (state_q != StResp)) begin
            rdata_d = (sel_err != ERR_NONE) ? 32'h0 : ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
            idx_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                wr_q    <= MemWrite;
                wdata_q <= WriteData;
                idx_q   <= req_idx;
                err_q   <= req_err;
            end
        end
    end

    // Commit happens on the edge that ends RESP; an async reset drops state and thus the enable.
    assign ram_we = (state_q == StResp) && wr_q && (err_q == ERR_NONE);

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(32)
    ) u_mem_array (
        .clk  (clk),
        .we   (ram_we),
        .widx (idx_q),
        .wdata(wdata_q),
        .ridx (sel_idx),
        .rdata(ram_rdata)
    );

    assign ReadData = rdata_q;
    assign MemReady = (state_q == StResp);
    assign MemErr   = (state_q == StResp) && (err_q != ERR_NONE);
    assign Busy     = (state_q != StIdle);

endmodule
